// File: rtl/handshake_source_gen.sv
// ---------------------------------------------------------------------------
// handshake_source_gen
//
// Purpose:
//   Synthesizable valid/ready stimulus source. On a start pulse it emits a
//   burst of data beats (increment, decrement, Galois-LFSR or constant
//   pattern). The beat rate is throttled by a free-running, reset-seeded
//   16-bit Fibonacci LFSR, so the sequence is fully deterministic.
//   Beats pass through a two-stage registered pipeline (generator stage,
//   output stage). A start/stop/done FSM controls each burst.
//
// Handshake:
//   A beat transfers on every rising clock edge where o_valid & i_ready.
//   While o_valid is high and i_ready is low, o_value and o_last are held
//   stable and o_valid stays high. o_valid never depends combinationally
//   on i_ready.
//
// Ports:
//   clock        in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   i_start      in   one-cycle pulse, starts a burst (honoured in IDLE only)
//   i_stop       in   ends generation early (honoured in RUN only)
//   i_mode       in   0=incr, 1=decr, 2=LFSR, 3=constant (sampled at start)
//   i_seed       in   first data value / LFSR seed (sampled at start)
//   i_count      in   beats in burst, 0=unbounded (sampled at start)
//   i_rate       in   throttle setting (sampled at start)
//   o_value      out  beat data
//   o_valid      out  beat valid
//   o_last       out  final beat of a counted burst, qualified by o_valid
//   i_ready      in   downstream ready
//   o_busy       out  FSM not IDLE
//   o_done       out  one-cycle pulse at burst completion
//   o_count      out  beats accepted in current/last burst (wraps)
//   o_dbg_state  out  current FSM state (0=IDLE,1=RUN,2=DRAIN,3=DONE)
// ---------------------------------------------------------------------------
module handshake_source_gen #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      CNT_W     = 16,
    parameter int unsigned      RATE_W    = 3,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [1:0]        i_mode,
    input  logic [WIDTH-1:0]  i_seed,
    input  logic [CNT_W-1:0]  i_count,
    input  logic [RATE_W-1:0] i_rate,
    output logic [WIDTH-1:0]  o_value,
    output logic              o_valid,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_count,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_INCR  = 2'd0;
    localparam logic [1:0] MODE_DECR  = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;

    // FSM
    state_t r_state;
    state_t w_state_next;

    // Burst configuration latched at start
    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_count_lim;
    logic [RATE_W-1:0] r_rate;

    // Throttle LFSR
    logic [15:0]       r_thr_lfsr;
    logic              w_thr_fb;
    logic              w_tick;

    // Generator stage
    logic [WIDTH-1:0]  r_gen_next_value;  // value the next generated beat carries
    logic [CNT_W-1:0]  r_gen_cnt;         // beats generated so far in this burst
    logic              r_gen_valid;
    logic [WIDTH-1:0]  r_gen_value;
    logic              r_gen_last;

    // Output stage
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_value;
    logic              r_out_last;

    // Accepted-beat counter
    logic [CNT_W-1:0]  r_acc_cnt;

    // Combinational helpers
    logic              w_start_accept;
    logic              w_s_ready;
    logic              w_m_ready;
    logic              w_limit_reached;
    logic              w_gen_fire;
    logic              w_gen_is_last;
    logic [CNT_W-1:0]  w_gen_cnt_inc;
    logic              w_count_hit;
    logic              w_pipe_empty;
    logic [WIDTH-1:0]  w_seed_value;
    logic [WIDTH-1:0]  w_advance_value;

    // -----------------------------------------------------------------------
    // Throttle: x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form.
    // Runs every cycle out of reset so the tick pattern depends only on the
    // number of cycles since reset.
    // -----------------------------------------------------------------------
    assign w_thr_fb = r_thr_lfsr[0] ^ r_thr_lfsr[2] ^ r_thr_lfsr[3] ^ r_thr_lfsr[5];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_thr_lfsr <= 16'hACE1;
        end else begin
            r_thr_lfsr <= {w_thr_fb, r_thr_lfsr[15:1]};
        end
    end

    // Low RATE_W bits are uniform over 2^RATE_W values, so this gives a
    // tick probability of (rate+1)/2^RATE_W; all-ones rate ticks always.
    assign w_tick = (r_thr_lfsr[RATE_W-1:0] <= r_rate);

    // -----------------------------------------------------------------------
    // Shared handshake / control terms
    // -----------------------------------------------------------------------
    assign w_start_accept  = (r_state == ST_IDLE) && i_start;
    assign w_m_ready       = ~r_out_valid | i_ready;
    assign w_s_ready       = ~r_gen_valid | w_m_ready;
    assign w_limit_reached = (r_count_lim != '0) && (r_gen_cnt == r_count_lim);
    assign w_gen_fire      = w_s_ready && (r_state == ST_RUN) && w_tick && !w_limit_reached;
    assign w_gen_cnt_inc   = r_gen_cnt + CNT_W'(1);
    assign w_gen_is_last   = (r_count_lim != '0) && (r_gen_cnt == (r_count_lim - CNT_W'(1)));
    // Count reached including the beat generated this cycle, so RUN is left
    // on the same edge that produces the last beat.
    assign w_count_hit     = (r_count_lim != '0) &&
                             ((w_gen_fire ? w_gen_cnt_inc : r_gen_cnt) == r_count_lim);
    assign w_pipe_empty    = !r_gen_valid && !r_out_valid;

    // A zero seed would lock the data LFSR, so it is replaced by all ones.
    assign w_seed_value = ((i_mode == MODE_LFSR) && (i_seed == '0)) ? '1 : i_seed;

    always_comb begin
        w_advance_value = r_gen_next_value;
        case (r_mode)
            MODE_INCR: w_advance_value = r_gen_next_value + WIDTH'(1);
            MODE_DECR: w_advance_value = r_gen_next_value - WIDTH'(1);
            MODE_LFSR: w_advance_value = {1'b0, r_gen_next_value[WIDTH-1:1]} ^
                                         (r_gen_next_value[0] ? LFSR_TAPS : '0);
            default:   w_advance_value = r_gen_next_value;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Count and stop both lead to DRAIN; the last flag of a
                // count-terminated beat does not depend on i_stop.
                if (w_count_hit || i_stop) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pipe_empty) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_busy      = (r_state != ST_IDLE);
        o_done      = (r_state == ST_DONE);
        o_dbg_state = r_state;
    end

    // -----------------------------------------------------------------------
    // Burst configuration
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode      <= '0;
            r_count_lim <= '0;
            r_rate      <= '0;
        end else if (w_start_accept) begin
            r_mode      <= i_mode;
            r_count_lim <= i_count;
            r_rate      <= i_rate;
        end
    end

    // -----------------------------------------------------------------------
    // Generator stage
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gen_next_value <= '0;
            r_gen_cnt        <= '0;
            r_gen_valid      <= 1'b0;
            r_gen_value      <= '0;
            r_gen_last       <= 1'b0;
        end else begin
            if (w_start_accept) begin
                r_gen_next_value <= w_seed_value;
                r_gen_cnt        <= '0;
            end else if (w_gen_fire) begin
                r_gen_next_value <= w_advance_value;
                r_gen_cnt        <= w_gen_cnt_inc;
            end

            if (w_s_ready) begin
                r_gen_valid <= w_gen_fire;
                if (w_gen_fire) begin
                    r_gen_value <= r_gen_next_value;
                    r_gen_last  <= w_gen_is_last;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output stage
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_value <= '0;
            r_out_last  <= 1'b0;
        end else if (w_m_ready) begin
            r_out_valid <= r_gen_valid;
            if (r_gen_valid) begin
                r_out_value <= r_gen_value;
                r_out_last  <= r_gen_last;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Accepted-beat counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc_cnt <= '0;
        end else if (w_start_accept) begin
            r_acc_cnt <= '0;
        end else if (r_out_valid && i_ready) begin
            r_acc_cnt <= r_acc_cnt + CNT_W'(1);
        end
    end

    assign o_value = r_out_value;
    assign o_valid = r_out_valid;
    assign o_last  = r_out_valid & r_out_last;
    assign o_count = r_acc_cnt;

endmodule

// File: tb/tb_handshake_source_gen.sv
// ---------------------------------------------------------------------------
// tb_handshake_source_gen
//
// Directed bench for handshake_source_gen. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge. A negedge
// monitor records every accepted beat (value, last flag, cycle stamp) and
// counts o_done pulses; bursts are then compared with hand-written
// expected queues.
// ---------------------------------------------------------------------------
module tb_handshake_source_gen;
  localparam int WIDTH  = 8;
  localparam int CNT_W  = 16;
  localparam int RATE_W = 3;

  // --------------------------------------------------------------- clock/reset
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic              i_start = 1'b0;
  logic              i_stop  = 1'b0;
  logic [1:0]        i_mode  = '0;
  logic [WIDTH-1:0]  i_seed  = '0;
  logic [CNT_W-1:0]  i_count = '0;
  logic [RATE_W-1:0] i_rate  = '0;
  logic              i_ready = 1'b1;
  logic [WIDTH-1:0]  o_value;
  logic              o_valid;
  logic              o_last;
  logic              o_busy;
  logic              o_done;
  logic [CNT_W-1:0]  o_count;
  logic [1:0]        o_dbg_state;

  handshake_source_gen #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .RATE_W(RATE_W), .LFSR_TAPS(8'hB8)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode), .i_seed(i_seed),
    .i_count(i_count), .i_rate(i_rate),
    .o_value(o_value), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready),
    .o_busy(o_busy), .o_done(o_done), .o_count(o_count), .o_dbg_state(o_dbg_state)
  );

  // --------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------- monitor
  logic [WIDTH-1:0] got_q[$];
  logic             got_last_q[$];
  int               got_cyc_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int               done_cnt = 0;
  int               cyc = 0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_val = '0;

  // Reference throttle LFSR: x^16+x^14+x^13+x^11+1 seeded with 16'hACE1.
  logic [15:0] m_lfsr;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n) begin
      if (o_valid && i_ready) begin
        got_q.push_back(o_value);
        got_last_q.push_back(o_last);
        got_cyc_q.push_back(cyc);
      end
      if (o_done) done_cnt <= done_cnt + 1;
      if (prev_stall) begin
        check_eq("stall_valid", o_valid, 1);
        check_eq("stall_hold", o_value, prev_val);
      end
      prev_stall <= o_valid && !i_ready;
      prev_val   <= o_value;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  // --------------------------------------------------------------- drivers
  task automatic clear_q();
    got_q.delete();
    got_last_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_start = 1'b0;
    i_stop  = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic start_burst(input logic [1:0] mode, input logic [WIDTH-1:0] seed,
                             input logic [CNT_W-1:0] count, input logic [RATE_W-1:0] rate);
    @(posedge clock); #1;
    i_mode  = mode;
    i_seed  = seed;
    i_count = count;
    i_rate  = rate;
    i_start = 1'b1;
    @(posedge clock); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clock); #1;
      n++;
    end
    check_eq({tag, "_done_seen"}, (done_cnt > d0), 1);
    repeat (3) begin
      @(negedge clock); #1;
    end
    check_eq({tag, "_done_once"}, done_cnt - d0, 1);
    check_eq({tag, "_idle"}, o_busy, 0);
  endtask

  task automatic compare_burst(input string tag, input int last_idx);
    check_eq({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check_eq($sformatf("%s_val%0d", tag, i), got_q[i], exp_q[i]);
        check_eq($sformatf("%s_last%0d", tag, i), got_last_q[i], (i == last_idx));
      end
    end
  endtask

  task automatic check_back_to_back(input string tag);
    for (int i = 1; i < got_cyc_q.size(); i++) begin
      check_eq($sformatf("%s_gap%0d", tag, i), got_cyc_q[i] - got_cyc_q[i-1], 1);
    end
  endtask

  task automatic run_directed(input string tag, input logic [1:0] mode,
                              input logic [WIDTH-1:0] seed, input logic [CNT_W-1:0] count,
                              input int last_idx);
    clear_q();
    start_burst(mode, seed, count, 3'd7);
    wait_done(tag, 200);
    compare_burst(tag, last_idx);
    check_eq({tag, "_ocount"}, o_count, count);
  endtask

  task automatic run_rate(input string tag, output int acc, output int ticks);
    do_reset();
    repeat (3) @(posedge clock);
    start_burst(2'd0, 8'h00, 16'd0, 3'd0);
    clear_q();
    ticks = 0;
    repeat (800) begin
      @(negedge clock); #1;
      if (m_lfsr[2:0] == 3'd0) ticks++;
    end
    acc = got_q.size();
    @(posedge clock); #1 i_stop = 1'b1;
    @(posedge clock); #1 i_stop = 1'b0;
    wait_done(tag, 100);
  endtask

  // --------------------------------------------------------------- watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    int acc1, acc2, ticks1, ticks2, diff, n, d0;

    do_reset();
    @(negedge clock); #1;
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_last",  o_last, 0);
    check_eq("rst_value", o_value, 0);
    check_eq("rst_busy",  o_busy, 0);
    check_eq("rst_done",  o_done, 0);
    check_eq("rst_count", o_count, 0);
    check_eq("rst_state", o_dbg_state, 0);

    // 1: increment burst, full rate, latency of two edges
    clear_q();
    i_ready = 1'b1;
    start_burst(2'd0, 8'h10, 16'd4, 3'd7);
    @(negedge clock); #1;
    check_eq("t1_busy", o_busy, 1);
    check_eq("t1_lat_n0", o_valid, 0);
    @(negedge clock); #1;
    check_eq("t1_lat_n1", o_valid, 0);
    @(negedge clock); #1;
    check_eq("t1_lat_n2", o_valid, 1);
    check_eq("t1_first", o_value, 8'h10);
    wait_done("t1", 200);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    compare_burst("t1", 3);
    check_back_to_back("t1");
    check_eq("t1_ocount", o_count, 4);

    // 2: stall for 5 cycles on the first beat
    clear_q();
    i_ready = 1'b0;
    start_burst(2'd0, 8'h10, 16'd4, 3'd7);
    n = 0;
    while (!o_valid && n < 10) begin
      @(negedge clock); #1;
      n++;
    end
    check_eq("t2_valid_seen", o_valid, 1);
    repeat (5) begin
      @(negedge clock); #1;
      check_eq("t2_hold", o_value, 8'h10);
      check_eq("t2_busy", o_busy, 1);
    end
    @(posedge clock); #1 i_ready = 1'b1;
    wait_done("t2", 200);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    compare_burst("t2", 3);
    check_back_to_back("t2");
    check_eq("t2_ocount", o_count, 4);

    // 3: data LFSR mode, including the zero-seed substitution
    exp_q = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
    run_directed("t3a", 2'd2, 8'h01, 16'd4, 3);
    exp_q = '{8'hFF};
    run_directed("t3b", 2'd2, 8'h00, 16'd1, 0);

    // 4: decrement with wrap, constant
    exp_q = '{8'h01, 8'h00, 8'hFF};
    run_directed("t4a", 2'd1, 8'h01, 16'd3, 2);
    exp_q = '{8'hA5, 8'hA5};
    run_directed("t4b", 2'd3, 8'hA5, 16'd2, 1);

    // 5: unbounded burst ended by stop; start during RUN is ignored
    clear_q();
    start_burst(2'd0, 8'h20, 16'd0, 3'd7);
    n = 0;
    while (got_q.size() < 2 && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    start_burst(2'd3, 8'h99, 16'd5, 3'd7);
    n = 0;
    while (got_q.size() < 6 && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    check_eq("t5_six_seen", (got_q.size() == 6), 1);
    // Stop is sampled on the edge that accepts the sixth beat; the beat in
    // the generator stage and the one generated on that edge still deliver.
    i_stop = 1'b1;
    @(posedge clock); #1 i_stop = 1'b0;
    wait_done("t5", 100);
    exp_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
    compare_burst("t5", -1);
    check_eq("t5_ocount", o_count, 8);

    // 6: lowest rate, determinism across two identical runs after reset
    run_rate("t6r1", acc1, ticks1);
    check_eq("t6_range", (acc1 >= 70 && acc1 <= 130), 1);
    diff = acc1 - ticks1;
    check_eq("t6_track", (diff >= -2 && diff <= 2), 1);
    run_rate("t6r2", acc2, ticks2);
    check_eq("t6_ticks_repeat", ticks2, ticks1);
    check_eq("t6_repeat", acc2, acc1);

    // 6b: reset in the middle of a burst
    clear_q();
    start_burst(2'd0, 8'h30, 16'd0, 3'd7);
    repeat (10) begin
      @(negedge clock); #1;
    end
    check_eq("t6b_pre_busy", o_busy, 1);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check_eq("t6b_valid", o_valid, 0);
    check_eq("t6b_busy", o_busy, 0);
    check_eq("t6b_count", o_count, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (10) begin
      @(negedge clock); #1;
    end
    check_eq("t6b_no_done", done_cnt - d0, 0);
    check_eq("t6b_idle_valid", o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
